// File: rtl/comp_minmax_stream_if.sv
// Operand/result bundle for the streaming min/max scanner.
// No logic: carries control, operand stream and result stream.
// Backpressure travels on in_ready (operands) and out_ready (result).
interface comp_minmax_stream_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic             energy;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             signed_mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] min_val;
  logic [WIDTH-1:0] max_val;
  logic [CNT_W-1:0] min_idx;
  logic [CNT_W-1:0] max_idx;
  logic             busy;

  // Requester side: drives control and operands, consumes the result.
  modport master (
    output energy, start, len, signed_mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, min_val, max_val, min_idx, max_idx, busy
  );

  // Scanner side.
  modport slave (
    input  energy, start, len, signed_mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, min_val, max_val, min_idx, max_idx, busy
  );
endinterface

// File: rtl/comp_minmax_stream.sv
// Scans a block of len operands, tracking running min/max and their first indices.
// out_valid rises one cycle after the last accepted beat (len+1 cycles minimum).
// in_ready only in ACCUM with energy=1; result held in DONE until out_ready (energy=1).
module comp_minmax_stream #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input logic                clk,
  input logic                rst_n,
  comp_minmax_stream_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   len_q;
  logic               mode_q;
  logic [WIDTH-1:0]   min_q, max_q;
  logic [CNT_W-1:0]   min_idx_q, max_idx_q;

  logic               start_ok;
  logic               beat;
  logic               out_fire;
  logic               in_ready_c;
  logic               out_valid_c;
  logic               busy_c;
  logic               lt_min, gt_max;
  logic signed [WIDTH:0] data_x, min_x, max_x;

  // Extend operands by one bit (sign or zero) so one signed compare covers both modes.
  always_comb begin
    data_x = {mode_q & bus.in_data[WIDTH-1], bus.in_data};
    min_x  = {mode_q & min_q[WIDTH-1], min_q};
    max_x  = {mode_q & max_q[WIDTH-1], max_q};
    lt_min = data_x < min_x;
    gt_max = data_x > max_x;
  end

  // Next-state and handshake decode; energy=0 blocks every event so nothing moves.
  always_comb begin
    state_nxt   = state;
    start_ok    = 1'b0;
    beat        = 1'b0;
    out_fire    = 1'b0;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    case (state)
      IDLE: begin
        start_ok = bus.energy && bus.start && (bus.len != '0);
        if (start_ok) state_nxt = ACCUM;
      end
      ACCUM: begin
        busy_c     = 1'b1;
        in_ready_c = bus.energy;
        beat       = bus.in_valid && in_ready_c;
        if (beat && (count == len_q - 1'b1)) state_nxt = DONE;
      end
      DONE: begin
        busy_c      = 1'b1;
        out_valid_c = 1'b1;
        out_fire    = bus.energy && bus.out_ready;
        if (out_fire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Block parameters are captured at start; running min/max update on accepted beats only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      len_q     <= '0;
      mode_q    <= 1'b0;
      min_q     <= '0;
      max_q     <= '0;
      min_idx_q <= '0;
      max_idx_q <= '0;
    end else if (start_ok) begin
      count  <= '0;
      len_q  <= bus.len;
      mode_q <= bus.signed_mode;
    end else if (beat) begin
      count <= count + 1'b1;
      if (count == '0) begin
        min_q     <= bus.in_data;
        max_q     <= bus.in_data;
        min_idx_q <= '0;
        max_idx_q <= '0;
      end else begin
        // Strict compares keep the earliest index on ties.
        if (lt_min) begin
          min_q     <= bus.in_data;
          min_idx_q <= count;
        end
        if (gt_max) begin
          max_q     <= bus.in_data;
          max_idx_q <= count;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.min_val   = min_q;
  assign bus.max_val   = max_q;
  assign bus.min_idx   = min_idx_q;
  assign bus.max_idx   = max_idx_q;

endmodule

// File: tb/tb_comp_minmax_stream.sv
// Directed bench for the streaming min/max scanner.
// Drives inputs 1 time unit after rising edges, samples on falling edges or post-edge.
// Exercises operand gaps, energy stalls and result backpressure.
module tb_comp_minmax_stream;
  localparam int WIDTH = 16;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [WIDTH-1:0] vec [16];

  always #5 clk = ~clk;

  comp_minmax_stream_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  comp_minmax_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic start_scan(input logic [CNT_W-1:0] l, input logic sm);
    @(posedge clk); #1;
    bus.start       = 1'b1;
    bus.len         = l;
    bus.signed_mode = sm;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.len   = '0;
    check("busy_accum", bus.busy, 1);
  endtask

  // Offers vec[lo..hi-1]; call at posedge+1, returns at posedge+1.
  task automatic feed(input int lo, input int hi, input bit gaps, input bit last);
    int   i;
    int   cyc;
    logic acc;
    logic ov_before;
    i = lo;
    cyc = 0;
    ov_before = 1'b0;
    while (i < hi && cyc < 100) begin
      bus.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.in_data  = vec[i];
      @(negedge clk);
      acc       = bus.in_valid && bus.in_ready;
      ov_before = bus.out_valid;
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    check("feed_budget", i, hi);
    if (last) begin
      check("ov_before_last", ov_before, 0);
      check("ov_after_last", bus.out_valid, 1);
    end
  endtask

  task automatic collect(input logic [WIDTH-1:0] emn, input logic [WIDTH-1:0] emx,
                         input logic [CNT_W-1:0] emni, input logic [CNT_W-1:0] emxi,
                         input int hold, input bit poke_start);
    check("min_val", bus.min_val, emn);
    check("max_val", bus.max_val, emx);
    check("min_idx", bus.min_idx, emni);
    check("max_idx", bus.max_idx, emxi);
    for (int k = 0; k < hold; k++) begin
      if (poke_start) begin
        bus.start = 1'b1;
        bus.len   = 8'd5;
      end
      @(negedge clk);
      check("ov_hold", bus.out_valid, 1);
      check("min_hold", bus.min_val, emn);
      check("max_hold", bus.max_val, emx);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    if (poke_start) begin
      bus.start = 1'b1;
      bus.len   = 8'd5;
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    bus.len       = '0;
    check("ov_drop", bus.out_valid, 0);
    check("busy_idle", bus.busy, 0);
    check("min_kept", bus.min_val, emn);
    check("max_idx_kept", bus.max_idx, emxi);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.energy      = 1'b1;
    bus.start       = 1'b0;
    bus.len         = '0;
    bus.signed_mode = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.out_ready   = 1'b0;
    #12;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_min_val", bus.min_val, 0);
    check("rst_max_val", bus.max_val, 0);
    check("rst_min_idx", bus.min_idx, 0);
    check("rst_max_idx", bus.max_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unsigned block: 0xFFFF is the max.
    vec[0] = 16'h0005; vec[1] = 16'hFFFF; vec[2] = 16'h0001; vec[3] = 16'h0007;
    start_scan(8'd4, 1'b0);
    feed(0, 4, 1'b0, 1'b1);
    collect(16'h0001, 16'hFFFF, 8'd2, 8'd1, 0, 1'b0);

    // Same data signed: 0xFFFF is -1.
    start_scan(8'd4, 1'b1);
    feed(0, 4, 1'b0, 1'b1);
    collect(16'hFFFF, 16'h0007, 8'd1, 8'd3, 0, 1'b0);

    // Signed extremes.
    vec[0] = 16'h7FFF; vec[1] = 16'h8000;
    start_scan(8'd2, 1'b1);
    feed(0, 2, 1'b0, 1'b1);
    collect(16'h8000, 16'h7FFF, 8'd1, 8'd0, 0, 1'b0);

    // Ties keep the first index.
    vec[0] = 16'd9; vec[1] = 16'd9; vec[2] = 16'd9;
    start_scan(8'd3, 1'b0);
    feed(0, 3, 1'b0, 1'b1);
    collect(16'd9, 16'd9, 8'd0, 8'd0, 0, 1'b0);

    // Single-operand block.
    vec[0] = 16'h1234;
    start_scan(8'd1, 1'b0);
    feed(0, 1, 1'b0, 1'b1);
    collect(16'h1234, 16'h1234, 8'd0, 8'd0, 0, 1'b0);

    // Stress: gaps, energy stall mid-scan, stray start, held result.
    vec[0] = 16'h0030; vec[1] = 16'h0010; vec[2] = 16'h0050;
    vec[3] = 16'h0010; vec[4] = 16'h0050; vec[5] = 16'h0005;
    start_scan(8'd6, 1'b0);
    feed(0, 2, 1'b1, 1'b0);
    bus.energy   = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = vec[2];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_in_ready", bus.in_ready, 0);
      @(posedge clk); #1;
    end
    check("stall_min", bus.min_val, 16'h0010);
    check("stall_min_idx", bus.min_idx, 1);
    check("stall_max", bus.max_val, 16'h0030);
    check("stall_max_idx", bus.max_idx, 0);
    bus.in_valid = 1'b0;
    bus.energy   = 1'b1;
    bus.start    = 1'b1;
    bus.len      = 8'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.len   = '0;
    feed(2, 6, 1'b1, 1'b1);
    bus.energy    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("stall_done_ov", bus.out_valid, 1);
    check("stall_done_busy", bus.busy, 1);
    bus.out_ready = 1'b0;
    bus.energy    = 1'b1;
    collect(16'h0005, 16'h0050, 8'd5, 8'd2, 5, 1'b1);

    // len=0 start is ignored.
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.len   = '0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("len0_busy", bus.busy, 0);
    check("len0_in_ready", bus.in_ready, 0);
    check("len0_min", bus.min_val, 16'h0005);

    // Asynchronous reset mid-scan, then a clean scan.
    vec[0] = 16'h0003; vec[1] = 16'hFFFB; vec[2] = 16'h0002; vec[3] = 16'h0100;
    start_scan(8'd4, 1'b1);
    feed(0, 2, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_min", bus.min_val, 0);
    check("arst_max", bus.max_val, 0);
    check("arst_max_idx", bus.max_idx, 0);
    check("arst_min_idx", bus.min_idx, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_in_ready", bus.in_ready, 0);
    check("arst_out_valid", bus.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_scan(8'd4, 1'b1);
    feed(0, 4, 1'b0, 1'b1);
    collect(16'hFFFB, 16'h0100, 8'd1, 8'd3, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
